// File: rtl/posit_defines_es3.sv
// Shared constants and types for the posit<8,3> datapath and its float front end.
package posit_defines_es3;

  localparam int NBITS     = 8;
  localparam int ES        = 3;
  // Largest |scale| a posit<8,3> can represent: maxpos = 2^48, minpos = 2^-48.
  localparam int MAXSCALE  = 48;
  localparam int FBITS_F32 = 23;

  // Unpacked binary32 operand: unbiased scale plus classification flags.
  typedef struct packed {
    logic                  sign;
    logic signed [8:0]     scale;
    logic [FBITS_F32-1:0]  fraction;
    logic                  zero;
    logic                  inf;
    logic                  subnormal;
  } float_value;

endpackage

// File: rtl/DSR_right_N_S.sv
// Logarithmic logical right shifter: c = a >> b, zero fill.
module DSR_right_N_S #(
  parameter int N = 16,
  parameter int S = 4
) (
  input  logic [N-1:0] a,
  input  logic [S-1:0] b,
  output logic [N-1:0] c
);

  logic [N-1:0] stg [0:S];

  assign stg[0] = a;

  for (genvar i = 0; i < S; i++) begin : g_stage
    // Each stage shifts by 2^i when the matching shift-amount bit is set.
    assign stg[i+1] = b[i] ? (stg[i] >> (1 << i)) : stg[i];
  end

  assign c = stg[S];

endmodule

// File: rtl/float_extract.sv
// Combinational binary32 unpacker: field split, classification and unbiasing.
module float_extract
  import posit_defines_es3::*;
(
  input  logic [31:0] f,
  output float_value  fv
);

  logic [7:0]           bexp;
  logic [FBITS_F32-1:0] mant;

  assign bexp = f[30:23];
  assign mant = f[22:0];

  // Classify the operand and remove the exponent bias.
  always_comb begin
    fv           = '0;
    fv.sign      = f[31];
    fv.scale     = $signed({1'b0, bexp}) - 9'sd127;
    fv.fraction  = mant;
    fv.inf       = (bexp == 8'hFF);
    fv.zero      = (bexp == 8'h00) && (mant == '0);
    fv.subnormal = (bexp == 8'h00) && (mant != '0);
  end

endmodule

// File: rtl/float_to_posit_8_es3.sv
// Pipelined binary32 -> posit<8,3> encoder, one conversion per cycle,
// done four edges after start is sampled.
// Build option: FLOAT_TO_POSIT_SUBNORMAL_EN makes subnormals saturate to
// +/-minpos instead of being flushed to zero.
module float_to_posit_8_es3
  import posit_defines_es3::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in,
  output logic [31:0] result,
  output logic        inf,
  output logic        zero,
  output logic        done
);

  localparam logic signed [8:0] SCALE_HI  = 9'(MAXSCALE);
  localparam logic signed [8:0] SCALE_LO  = 9'sd0 - SCALE_HI;
  localparam logic signed [6:0] SCALE_HI7 = 7'(MAXSCALE);
  localparam logic signed [6:0] SCALE_LO7 = 7'sd0 - SCALE_HI7;
  localparam int                SHW       = 34;

  // ---------------- stage 0 ----------------
  logic [31:0] in_clean;
  logic        start_clean;
  logic        v0;
  logic [31:0] in_q;

  // Unknown input bits are captured as 0 so X never enters the pipeline.
  always_comb begin
    in_clean = '0;
    for (int i = 0; i < 32; i++) in_clean[i] = (in[i] === 1'b1);
    start_clean = (start === 1'b1);
  end

  // Input capture register.
  always_ff @(posedge clk) begin
    if (reset) begin
      v0   <= 1'b0;
      in_q <= '0;
    end else begin
      v0   <= start_clean;
      in_q <= in_clean;
    end
  end

  // ---------------- stage 1 ----------------
  float_value fv;

  float_extract u_extract (
    .f  (in_q),
    .fv (fv)
  );

  logic                  sat_low;
  logic                  zero_c;
  logic signed [6:0]     scale_c;
  logic [FBITS_F32-1:0]  frac_c;

  logic                  v1, sign1, nar1, zero1;
  logic signed [6:0]     scale1;
  logic [FBITS_F32-1:0]  frac1;

  // Clamp the scale into the posit range; a clamped value loses its fraction
  // so it lands exactly on maxpos/minpos.
  always_comb begin
`ifdef FLOAT_TO_POSIT_SUBNORMAL_EN
    sat_low = fv.subnormal || ($signed(fv.scale) < SCALE_LO);
    zero_c  = fv.zero;
`else
    sat_low = $signed(fv.scale) < SCALE_LO;
    zero_c  = fv.zero || fv.subnormal;
`endif
    scale_c = fv.scale[6:0];
    frac_c  = fv.fraction;
    if ($signed(fv.scale) > SCALE_HI) begin
      scale_c = SCALE_HI7;
      frac_c  = '0;
    end else if (sat_low) begin
      scale_c = SCALE_LO7;
      frac_c  = '0;
    end
  end

  // Unpacked-operand register.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1     <= 1'b0;
      sign1  <= 1'b0;
      nar1   <= 1'b0;
      zero1  <= 1'b0;
      scale1 <= '0;
      frac1  <= '0;
    end else begin
      v1     <= v0;
      sign1  <= fv.sign;
      nar1   <= fv.inf;
      zero1  <= zero_c;
      scale1 <= scale_c;
      frac1  <= frac_c;
    end
  end

  // ---------------- stage 2 ----------------
  logic [3:0]     k;
  logic           rbit;
  logic [2:0]     run_len;
  logic [SHW-1:0] shf_in, shf_out, enc;

  // Regime run: k >= 0 gives k+1 ones, k < 0 gives -k zeros. The vector
  // is conditionally inverted around the zero-filling shifter so a run of
  // ones can be produced by the same shift.
  always_comb begin
    k       = scale1[6:3];
    rbit    = ~k[3];
    run_len = rbit ? (k[2:0] + 3'd1) : (3'd0 - k[2:0]);
    shf_in  = {1'b1, {scale1[ES-1:0], frac1, 7'b0} ^ {(SHW-1){rbit}}};
    enc     = shf_out ^ {SHW{rbit}};
  end

  DSR_right_N_S #(.N(SHW), .S(3)) u_regime_shift (
    .a (shf_in),
    .b (run_len),
    .c (shf_out)
  );

  logic       v2, sign2, nar2, zero2, guard2, sticky2;
  logic [6:0] mag2;

  // Truncated encoding plus guard/sticky for rounding.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2      <= 1'b0;
      sign2   <= 1'b0;
      nar2    <= 1'b0;
      zero2   <= 1'b0;
      mag2    <= '0;
      guard2  <= 1'b0;
      sticky2 <= 1'b0;
    end else begin
      v2      <= v1;
      sign2   <= sign1;
      nar2    <= nar1;
      zero2   <= zero1;
      mag2    <= enc[SHW-1 -: 7];
      guard2  <= enc[SHW-8];
      sticky2 <= |enc[SHW-9:0];
    end
  end

  // ---------------- stage 3 ----------------
  logic             rnd;
  logic [NBITS-1:0] mag_rnd, mag_sat, word_c;

  // Round to nearest even, keep the magnitude within [minpos, maxpos],
  // then apply the sign as a two's complement.
  always_comb begin
    rnd     = guard2 & (sticky2 | mag2[0]);
    mag_rnd = {1'b0, mag2} + {7'b0, rnd};
    mag_sat = mag_rnd;
    if (mag_rnd[NBITS-1])    mag_sat = 8'h7F;
    else if (mag_rnd == '0)  mag_sat = 8'h01;
    word_c  = sign2 ? (8'h00 - mag_sat) : mag_sat;
  end

  logic             v3, nar3, zero3;
  logic [NBITS-1:0] word3;

  // Rounded, signed posit word.
  always_ff @(posedge clk) begin
    if (reset) begin
      v3    <= 1'b0;
      nar3  <= 1'b0;
      zero3 <= 1'b0;
      word3 <= '0;
    end else begin
      v3    <= v2;
      nar3  <= nar2;
      zero3 <= zero2;
      word3 <= word_c;
    end
  end

  // Output register: special-case substitution, held while no result is due.
  always_ff @(posedge clk) begin
    if (reset) begin
      done   <= 1'b0;
      result <= '0;
      inf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      done <= v3;
      if (v3) begin
        if (nar3) begin
          result <= {24'b0, 8'h80};
          inf    <= 1'b1;
          zero   <= 1'b0;
        end else if (zero3) begin
          result <= '0;
          inf    <= 1'b0;
          zero   <= 1'b1;
        end else begin
          result <= {24'b0, word3};
          inf    <= 1'b0;
          zero   <= 1'b0;
        end
      end
    end
  end

endmodule
